// File: rtl/tm_output_packer.sv
// rtl/tm_output_packer.sv - requantize, pack and write back Tm output channels per pixel
// Optional feature macro: TPROC_OUT_RELU_EN clamps negative features to zero before requantization.

module tm_output_packer_fifo #(
  parameter int WIDTH = 80,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic             full
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW-1:0] == rptr[AW-1:0]) && (wptr[AW] != rptr[AW]);
  // Gated so the read port shows zero whenever nothing is queued, including after reset.
  assign rdata = empty ? '0 : mem[rptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr[AW-1:0]] <= wdata;
  end
endmodule

module tm_output_packer #(
  parameter int Tm            = 8,
  parameter int FEATURE_WIDTH = 16,
  parameter int OUT_WIDTH     = 8,
  parameter int ADDR_WIDTH    = 16,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      cfg_start,
  input  logic [ADDR_WIDTH-1:0]     cfg_base_addr,
  input  logic [15:0]               cfg_pixel_count,
  input  logic [3:0]                cfg_shift,
  input  logic                      in_valid,
  input  logic [FEATURE_WIDTH-1:0]  in_data,
  input  logic [4:0]                in_ch,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [Tm*OUT_WIDTH-1:0]   out_data,
  output logic [ADDR_WIDTH-1:0]     out_addr,
  output logic                      busy,
  output logic                      done,
  output logic                      err_order,
  output logic                      err_overflow
);
  localparam int CW = $clog2(Tm);
  localparam int DW = Tm * OUT_WIDTH;
  localparam int WW = DW + ADDR_WIDTH;
  localparam int XW = FEATURE_WIDTH + 1;
  localparam logic signed [XW-1:0] SAT_HI = XW'((2 ** (OUT_WIDTH - 1)) - 1);
  localparam logic signed [XW-1:0] SAT_LO = ~SAT_HI;

  typedef enum logic [1:0] {IDLE, COLLECT, DRAIN, DONE} state_t;

  state_t                 state;
  logic [ADDR_WIDTH-1:0]  base_addr;
  logic [ADDR_WIDTH-1:0]  pend_addr;
  logic [15:0]            pixel_count;
  logic [15:0]            pixel_idx;
  logic [3:0]             shift;
  logic [CW-1:0]          exp_ch;
  logic [DW-1:0]          pack;
  logic                   pend;

  logic signed [XW-1:0]   x_ext;
  logic [XW-1:0]          half;
  logic signed [XW-1:0]   sum;
  logic signed [XW-1:0]   rounded;
  logic [OUT_WIDTH-1:0]   lane_q;

  logic                   ch_ok;
  logic                   last_ch;
  logic                   fifo_push;
  logic                   fifo_pop;
  logic                   fifo_empty;
  logic                   fifo_full;
  logic [WW-1:0]          fifo_rdata;

  // With shift=0 the rounding constant collapses to zero, so one path covers both cases.
  always_comb begin
    x_ext = {in_data[FEATURE_WIDTH-1], in_data};
`ifdef TPROC_OUT_RELU_EN
    if (in_data[FEATURE_WIDTH-1]) x_ext = '0;
`endif
    half    = (XW'(1) << shift) >> 1;
    sum     = x_ext + $signed(half);
    rounded = sum >>> shift;
    if (rounded > SAT_HI)      lane_q = SAT_HI[OUT_WIDTH-1:0];
    else if (rounded < SAT_LO) lane_q = SAT_LO[OUT_WIDTH-1:0];
    else                       lane_q = rounded[OUT_WIDTH-1:0];
  end

  assign ch_ok     = (in_ch == 5'(exp_ch));
  assign last_ch   = (exp_ch == CW'(Tm - 1));
  assign fifo_pop  = !fifo_empty && out_ready;
  assign fifo_push = pend && (!fifo_full || fifo_pop);
  assign out_valid = !fifo_empty;
  assign out_data  = fifo_rdata[WW-1 -: DW];
  assign out_addr  = fifo_rdata[ADDR_WIDTH-1:0];

  tm_output_packer_fifo #(.WIDTH(WW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata ({pack, pend_addr}),
    .rdata (fifo_rdata),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      base_addr    <= '0;
      pend_addr    <= '0;
      pixel_count  <= '0;
      pixel_idx    <= '0;
      shift        <= '0;
      exp_ch       <= '0;
      pack         <= '0;
      pend         <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err_order    <= 1'b0;
      err_overflow <= 1'b0;
    end else begin
      // A completed pixel is pushed one edge after its last channel lands in the pack register.
      if (pend) begin
        pend <= 1'b0;
        if (fifo_full && !fifo_pop) err_overflow <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (cfg_start) begin
            base_addr    <= cfg_base_addr;
            pixel_count  <= cfg_pixel_count;
            shift        <= cfg_shift;
            exp_ch       <= '0;
            pixel_idx    <= '0;
            err_order    <= 1'b0;
            err_overflow <= 1'b0;
            busy         <= 1'b1;
            // An empty tile passes through the drain check so done still follows one edge later.
            state        <= (cfg_pixel_count == 16'd0) ? DRAIN : COLLECT;
          end
        end
        COLLECT: begin
          if (in_valid) begin
            if (!ch_ok) begin
              err_order <= 1'b1;
            end else begin
              pack[int'(exp_ch)*OUT_WIDTH +: OUT_WIDTH] <= lane_q;
              exp_ch <= last_ch ? '0 : exp_ch + 1'b1;
              if (last_ch) begin
                pend      <= 1'b1;
                pend_addr <= base_addr + ADDR_WIDTH'(pixel_idx);
                pixel_idx <= pixel_idx + 16'd1;
                if (pixel_idx + 16'd1 == pixel_count) state <= DRAIN;
              end
            end
          end
        end
        DRAIN: begin
          if (fifo_empty && !pend) begin
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_tm_output_packer.sv
// tb/tb_tm_output_packer.sv - randomized self-checking bench for tm_output_packer with a queue-based model
`timescale 1ns/1ps
module tb_tm_output_packer;
  localparam int TM = 8, FW = 16, OW = 8, AW = 16, DEPTH = 4;
  localparam int DW = TM * OW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          cfg_start = 1'b0;
  logic [AW-1:0] cfg_base_addr = '0;
  logic [15:0]   cfg_pixel_count = '0;
  logic [3:0]    cfg_shift = '0;
  logic          in_valid = 1'b0;
  logic [FW-1:0] in_data = '0;
  logic [4:0]    in_ch = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [DW-1:0] out_data;
  logic [AW-1:0] out_addr;
  logic          busy, done, err_order, err_overflow;

  always #5 clk = ~clk;

  tm_output_packer #(.Tm(TM), .FEATURE_WIDTH(FW), .OUT_WIDTH(OW), .ADDR_WIDTH(AW), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start), .cfg_base_addr(cfg_base_addr),
    .cfg_pixel_count(cfg_pixel_count), .cfg_shift(cfg_shift), .in_valid(in_valid),
    .in_data(in_data), .in_ch(in_ch), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_addr(out_addr), .busy(busy), .done(done),
    .err_order(err_order), .err_overflow(err_overflow)
  );

  int n_tests = 0, n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct packed {logic [DW-1:0] data; logic [AW-1:0] addr;} word_t;
  word_t mq[$];
  word_t popped[$];
  word_t m_pw;
  bit    m_busy, m_done, m_coll, m_drain, m_pend, m_eo, m_ovf, m_busy0;
  int    m_exp, m_pix, m_cnt, m_shift, m_base;
  int    lanes[TM];
  int    done_cnt = 0;
  bit    rand_ready = 0;

  function automatic int requant(input int x, input int s);
    int v = x;
`ifdef TPROC_OUT_RELU_EN
    if (v < 0) v = 0;
`endif
    if (s > 0) v = (v + (1 << (s - 1))) >>> s;
    if (v > (1 << (OW - 1)) - 1) v = (1 << (OW - 1)) - 1;
    if (v < -(1 << (OW - 1))) v = -(1 << (OW - 1));
    return v;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_busy = 0; m_done = 0; m_coll = 0; m_drain = 0; m_pend = 0; m_eo = 0; m_ovf = 0;
    end else begin
      m_busy0 = m_busy;
      if (m_done) begin
        m_done = 0; m_busy = 0;
      end else if (m_drain && mq.size() == 0 && !m_pend) begin
        m_done = 1; m_drain = 0;
      end
      if (mq.size() > 0 && out_ready) void'(mq.pop_front());
      if (m_pend) begin
        if (mq.size() < DEPTH) mq.push_back(m_pw);
        else m_ovf = 1;
        m_pend = 0;
      end
      if (m_coll && in_valid) begin
        if (int'(in_ch) != m_exp) m_eo = 1;
        else begin
          lanes[m_exp] = requant(int'($signed(in_data)), m_shift);
          if (m_exp == TM - 1) begin
            for (int c = 0; c < TM; c++) m_pw.data[c*OW +: OW] = lanes[c][OW-1:0];
            m_pw.addr = AW'(m_base + m_pix);
            m_pend = 1;
            m_pix++;
            if (m_pix == m_cnt) begin m_coll = 0; m_drain = 1; end
          end
          m_exp = (m_exp + 1) % TM;
        end
      end
      if (!m_busy0 && cfg_start) begin
        m_base = int'(cfg_base_addr); m_cnt = int'(cfg_pixel_count); m_shift = int'(cfg_shift);
        m_exp = 0; m_pix = 0; m_eo = 0; m_ovf = 0; m_busy = 1;
        if (m_cnt == 0) m_drain = 1; else m_coll = 1;
      end
    end
  end

  always @(negedge clk) begin
    chk("out_valid", 64'(out_valid), 64'(mq.size() > 0));
    if (mq.size() > 0) begin
      chk("out_data", 64'(out_data), 64'(mq[0].data));
      chk("out_addr", 64'(out_addr), 64'(mq[0].addr));
    end else begin
      chk("out_data_idle", 64'(out_data), 64'd0);
      chk("out_addr_idle", 64'(out_addr), 64'd0);
    end
    chk("busy", 64'(busy), 64'(m_busy));
    chk("done", 64'(done), 64'(m_done));
    chk("err_order", 64'(err_order), 64'(m_eo));
    chk("err_overflow", 64'(err_overflow), 64'(m_ovf));
    if (done) done_cnt++;
    if (out_valid && out_ready) popped.push_back({out_data, out_addr});
  end

  always @(posedge clk) if (rand_ready) begin #1; out_ready = ($urandom_range(0, 9) < 7); end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic start_tile(input int base, input int cnt, input int sh);
    cfg_base_addr = AW'(base); cfg_pixel_count = 16'(cnt); cfg_shift = 4'(sh);
    cfg_start = 1'b1; cyc(); cfg_start = 1'b0;
  endtask

  task automatic beat(input int ch, input int val);
    in_valid = 1'b1; in_ch = 5'(ch); in_data = FW'(val); cyc(); in_valid = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int k = 0;
    while (!done && k < budget) begin cyc(); k++; end
    chk(name, 64'(done), 64'd1);
    cyc();
  endtask

  initial begin
    int vals[TM];
    int cnt, bad;
    #1 rst_n = 1'b0;
    repeat (2) cyc();
    rst_n = 1'b1;
    cyc();

    // Basic pack
    popped.delete(); done_cnt = 0;
    start_tile(16'h0100, 2, 0);
    for (int p = 0; p < 2; p++) for (int c = 0; c < TM; c++) beat(c, p * TM + c + 1);
    wait_done("basic_done", 200);
    repeat (2) cyc();
    chk("basic_done_once", 64'(done_cnt), 64'd1);
    chk("basic_n", 64'(popped.size()), 64'd2);
    chk("basic_w0", 64'(popped[0].data), 64'h0807060504030201);
    chk("basic_a0", 64'(popped[0].addr), 64'h0100);
    chk("basic_w1", 64'(popped[1].data), 64'h100F0E0D0C0B0A09);
    chk("basic_a1", 64'(popped[1].addr), 64'h0101);

    // Rounding and saturation
    popped.delete();
    vals = '{5, 6, -6, 1000, -1000, 0, 0, 0};
    start_tile(16'h0200, 1, 2);
    for (int c = 0; c < TM; c++) beat(c, vals[c]);
    wait_done("round_done", 200);
    chk("round_w", 64'(popped[0].data), 64'h000000807FFF0201);

    // Order error: ch3 arrives early and is dropped
    popped.delete();
    start_tile(16'h0300, 1, 0);
    beat(0, 1); beat(1, 2); beat(3, 8'h55);
    for (int c = 2; c < TM; c++) beat(c, c + 1);
    wait_done("order_done", 200);
    chk("order_err", 64'(err_order), 64'd1);
    chk("order_w", 64'(popped[0].data), 64'h0807060504030201);

    // Backpressure and overflow
    popped.delete(); done_cnt = 0;
    out_ready = 1'b0;
    start_tile(16'h0400, 6, 0);
    for (int p = 0; p < 6; p++) for (int c = 0; c < TM; c++) beat(c, p * 16 + c);
    repeat (3) cyc();
    chk("bp_overflow", 64'(err_overflow), 64'd1);
    chk("bp_valid", 64'(out_valid), 64'd1);
    chk("bp_busy", 64'(busy), 64'd1);
    out_ready = 1'b1;
    wait_done("bp_done", 200);
    chk("bp_n", 64'(popped.size()), 64'd4);
    for (int i = 0; i < 4; i++) chk("bp_addr", 64'(popped[i].addr), 64'(16'h0400 + i));
    chk("bp_done_once", 64'(done_cnt), 64'd1);

    // Reset mid-tile, then an empty tile
    popped.delete();
    start_tile(16'h0500, 2, 0);
    beat(0, 1); beat(1, 2); beat(2, 3);
    rst_n = 1'b0; #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_out_addr", 64'(out_addr), 64'd0);
    chk("rst_busy", 64'({busy, done, err_order, err_overflow}), 64'd0);
    cyc(); rst_n = 1'b1; cyc();
    start_tile(16'h0600, 0, 0);
    chk("empty_done_early", 64'(done), 64'd0);
    cyc();
    chk("empty_done", 64'(done), 64'd1);
    cyc();
    chk("empty_done_low", 64'({done, busy}), 64'd0);
    chk("empty_no_word", 64'(popped.size()), 64'd0);

    // Negative input at shift 0
    popped.delete();
    start_tile(16'h0700, 1, 0);
    beat(0, -50);
    for (int c = 1; c < TM; c++) beat(c, c);
    wait_done("neg_done", 200);
`ifdef TPROC_OUT_RELU_EN
    chk("neg_lane0", 64'(popped[0].data[7:0]), 64'h00);
`else
    chk("neg_lane0", 64'(popped[0].data[7:0]), 64'hCE);
`endif

    // Randomized tiles with gaps, stray channels and ready stalls
    rand_ready = 1;
    for (int t = 0; t < 12; t++) begin
      cnt = $urandom_range(1, 5);
      bad = 0;
      start_tile((t % 3 == 0) ? 16'hFFFE : int'($urandom_range(0, 65535)), cnt, $urandom_range(0, 15));
      for (int p = 0; p < cnt; p++) begin
        for (int c = 0; c < TM; c++) begin
          if ($urandom_range(0, 7) == 0) begin in_data = FW'($urandom); cyc(); end
          if ($urandom_range(0, 15) == 0) begin beat(c + 1 + $urandom_range(0, 20), $urandom); bad = 1; end
          beat(c, $urandom);
        end
      end
      wait_done("rand_done", 2000);
      chk("rand_err_order", 64'(err_order), 64'(bad));
      chk("rand_fifo_empty", 64'(out_valid), 64'd0);
    end
    rand_ready = 0;
    cyc();
    out_ready = 1'b1;
    repeat (3) cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
